// File: rtl/vsa_pkg.sv
// Shared constants and types for the very-simple-architecture core
// and its memory subsystem.
package vsa_pkg;

    localparam int IADDR_W = 5;
    localparam int IWIDTH  = 12;
    localparam int DWIDTH  = 5;
    localparam int IDEPTH  = 1 << IADDR_W;

    typedef enum logic [1:0] {
        LOAD_LO = 2'd0,
        LOAD_HI = 2'd1,
        RUN     = 2'd2,
        ERR     = 2'd3
    } ld_state_e;

    // Opcode in instruction[11:8]; all-zero word is LW R0, a no-op write-back
    localparam logic [3:0] OP_LW  = 4'h0;
    localparam logic [3:0] OP_SW  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_BEQ = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;

endpackage

// File: rtl/vsa_loader_fsm.sv
// Byte-stream program loader: pairs LO/HI bytes into 12-bit words,
// checks the protocol and releases the core once the program is in.
module vsa_loader_fsm
    import vsa_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ld_valid_i,
    input  logic [7:0]         ld_data_i,
    input  logic               ld_last_i,
    output logic               ld_ready_o,
    output logic               ld_error_o,
    output logic               cpu_run_o,
    output logic               imem_we_o,
    output logic [IADDR_W-1:0] imem_waddr_o,
    output logic [IWIDTH-1:0]  imem_wdata_o
);

    ld_state_e          state_q, state_d;
    logic [IADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]         lo_q, lo_d;
    logic               hi_ok;

    assign hi_ok = (ld_data_i[7:4] == 4'h0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOAD_LO;
            waddr_q <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        lo_d    = lo_q;
        unique case (state_q)
            LOAD_LO: begin
                if (ld_valid_i) begin
                    lo_d    = ld_data_i;
                    state_d = ld_last_i ? ERR : LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (ld_valid_i) begin
                    if (!hi_ok) begin
                        state_d = ERR;
                    // No wrap: the word at the top address always ends the load
                    end else if (ld_last_i || (waddr_q == '1)) begin
                        state_d = RUN;
                    end else begin
                        waddr_d = waddr_q + 1'b1;
                        state_d = LOAD_LO;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_ready_o   = (state_q == LOAD_LO) || (state_q == LOAD_HI);
        cpu_run_o    = (state_q == RUN);
        ld_error_o   = (state_q == ERR);
        imem_we_o    = (state_q == LOAD_HI) && ld_valid_i && hi_ok;
        imem_waddr_o = waddr_q;
        imem_wdata_o = {ld_data_i[3:0], lo_q};
    end

endmodule

// File: rtl/vsa_mem_sub.sv
// Instruction and data memories around the VSA core, plus the
// program loader that gates the core until the image is in place.
module vsa_mem_sub
    import vsa_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ld_valid,
    input  logic [7:0]         ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               ld_error,
    output logic               cpu_run,
    input  logic [IADDR_W-1:0] pc,
    output logic [IWIDTH-1:0]  instruction,
    input  logic [IADDR_W-1:0] addr,
    input  logic [DWIDTH-1:0]  wdata,
    input  logic               wr,
    output logic [DWIDTH-1:0]  datain
);

    logic [IWIDTH-1:0]  imem_q [IDEPTH];
    logic [DWIDTH-1:0]  dmem_q [IDEPTH];
    logic               imem_we;
    logic [IADDR_W-1:0] imem_waddr;
    logic [IWIDTH-1:0]  imem_wdata;

    vsa_loader_fsm u_loader (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .ld_valid_i   (ld_valid),
        .ld_data_i    (ld_data),
        .ld_last_i    (ld_last),
        .ld_ready_o   (ld_ready),
        .ld_error_o   (ld_error),
        .cpu_run_o    (cpu_run),
        .imem_we_o    (imem_we),
        .imem_waddr_o (imem_waddr),
        .imem_wdata_o (imem_wdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < IDEPTH; i++) imem_q[i] <= '0;
        end else if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < IDEPTH; i++) dmem_q[i] <= '0;
        end else if (wr && cpu_run) begin
            dmem_q[addr] <= wdata;
        end
    end

    // Outside RUN the core sees LW R0, which has no architectural effect
    assign instruction = cpu_run ? imem_q[pc] : '0;
    assign datain      = dmem_q[addr];

endmodule

// File: tb/tb_vsa_mem_sub.sv
// Directed bench for vsa_mem_sub: load protocol, fetch, data memory
// and reset behaviour.
module tb_vsa_mem_sub;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_error;
    logic        cpu_run;
    logic [4:0]  pc;
    logic [11:0] instruction;
    logic [4:0]  addr;
    logic [4:0]  wdata;
    logic        wr;
    logic [4:0]  datain;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    vsa_mem_sub dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_error    (ld_error),
        .cpu_run     (cpu_run),
        .pc          (pc),
        .instruction (instruction),
        .addr        (addr),
        .wdata       (wdata),
        .wr          (wr),
        .datain      (datain)
    );

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        ld_valid = 1'b0;
        ld_data = 8'h00;
        ld_last = 1'b0;
        wr = 1'b0;
        pc = '0;
        addr = '0;
        wdata = '0;
        #3;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        @(negedge clock);
        ld_valid = 1'b1;
        ld_data = d;
        ld_last = last;
        @(posedge clock);
        #1;
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic check_instr(input logic [4:0] p, input logic [11:0] exp,
                               input string name);
        pc = p;
        #1;
        vectors++;
        if (instruction !== exp) begin
            errors++;
            $display("FAIL %s: instruction=%h expected %h", name, instruction, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors += 5;
        if (ld_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", ld_ready);
        end
        if (ld_error !== 1'b0) begin
            errors++; $display("FAIL reset_error: got %b expected 0", ld_error);
        end
        if (cpu_run !== 1'b0) begin
            errors++; $display("FAIL reset_run: got %b expected 0", cpu_run);
        end
        if (instruction !== 12'h000) begin
            errors++; $display("FAIL reset_instr: got %h expected 000", instruction);
        end
        if (datain !== 5'h00) begin
            errors++; $display("FAIL reset_datain: got %h expected 00", datain);
        end
    endtask

    task automatic test_normal_load();
        do_reset();
        send_byte(8'h0A, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h21, 1'b0);
        vectors++;
        if (cpu_run !== 1'b0) begin
            errors++; $display("FAIL load_run_early: cpu_run=%b expected 0", cpu_run);
        end
        send_byte(8'h03, 1'b1);
        vectors += 2;
        if (cpu_run !== 1'b1) begin
            errors++; $display("FAIL load_run: cpu_run=%b expected 1", cpu_run);
        end
        if (ld_ready !== 1'b0) begin
            errors++; $display("FAIL load_ready_run: ld_ready=%b expected 0", ld_ready);
        end
        check_instr(5'd0, 12'h60A, "load_pc0");
        check_instr(5'd1, 12'h321, "load_pc1");
        check_instr(5'd2, 12'h000, "load_pc2");
    endtask

    task automatic test_dmem();
        // still in RUN from the normal load
        @(negedge clock);
        addr = 5'd7;
        wdata = 5'h15;
        wr = 1'b1;
        #1;
        vectors++;
        if (datain !== 5'h00) begin
            errors++; $display("FAIL dmem_old: datain=%h expected 00", datain);
        end
        @(posedge clock);
        #1;
        wr = 1'b0;
        vectors++;
        if (datain !== 5'h15) begin
            errors++; $display("FAIL dmem_new: datain=%h expected 15", datain);
        end
        addr = 5'd8;
        #1;
        vectors++;
        if (datain !== 5'h00) begin
            errors++; $display("FAIL dmem_other: datain=%h expected 00", datain);
        end
    endtask

    task automatic test_reset_mid_run();
        addr = 5'd7;
        pc = 5'd0;
        #1;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        vectors += 3;
        if (cpu_run !== 1'b0) begin
            errors++; $display("FAIL rrun_run: cpu_run=%b expected 0", cpu_run);
        end
        if (instruction !== 12'h000) begin
            errors++; $display("FAIL rrun_instr: instruction=%h expected 000", instruction);
        end
        if (datain !== 5'h00) begin
            errors++; $display("FAIL rrun_dmem: datain=%h expected 00", datain);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_dmem_prerun();
        do_reset();
        @(negedge clock);
        addr = 5'd7;
        wdata = 5'h15;
        wr = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        wr = 1'b0;
        vectors++;
        if (datain !== 5'h00) begin
            errors++; $display("FAIL dmem_prerun: datain=%h expected 00", datain);
        end
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b1);
        #1;
        vectors++;
        if (datain !== 5'h00 || cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL dmem_prerun_run: datain=%h run=%b expected 00/1", datain, cpu_run);
        end
    endtask

    task automatic test_errors();
        do_reset();
        send_byte(8'h0A, 1'b1);
        vectors += 3;
        if (ld_error !== 1'b1) begin
            errors++; $display("FAIL err_odd: ld_error=%b expected 1", ld_error);
        end
        if (cpu_run !== 1'b0) begin
            errors++; $display("FAIL err_odd_run: cpu_run=%b expected 0", cpu_run);
        end
        if (ld_ready !== 1'b0) begin
            errors++; $display("FAIL err_odd_ready: ld_ready=%b expected 0", ld_ready);
        end
        do_reset();
        send_byte(8'h55, 1'b0);
        send_byte(8'h10, 1'b0);
        vectors += 2;
        if (ld_error !== 1'b1) begin
            errors++; $display("FAIL err_hi: ld_error=%b expected 1", ld_error);
        end
        if (dut.imem_q[0] !== 12'h000) begin
            errors++; $display("FAIL err_hi_imem: imem[0]=%h expected 000", dut.imem_q[0]);
        end
        send_byte(8'h00, 1'b1);
        vectors++;
        if (ld_error !== 1'b1 || cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: error=%b run=%b expected 1/0", ld_error, cpu_run);
        end
    endtask

    function automatic logic [11:0] bp_word(input int k);
        logic [7:0] lo;
        logic [3:0] hi;
        lo = 8'(k * 7 + 3);
        hi = 4'(k) ^ 4'h9;
        return {hi, lo};
    endfunction

    task automatic test_back_pressure();
        int         sent;
        int         cycles;
        logic [11:0] w;
        do_reset();
        sent = 0;
        cycles = 0;
        while (sent < 64 && cycles < 1000) begin
            @(negedge clock);
            w = bp_word(sent / 2);
            ld_valid = 1'($urandom_range(0, 1));
            ld_last = 1'b0;
            ld_data = (sent % 2 == 0) ? w[7:0] : {4'h0, w[11:8]};
            @(posedge clock);
            if (ld_valid && ld_ready) sent++;
            cycles++;
        end
        #1;
        ld_valid = 1'b0;
        vectors++;
        if (sent != 64) begin
            errors++; $display("FAIL bp_timeout: accepted %0d bytes expected 64", sent);
        end
        vectors += 2;
        if (cpu_run !== 1'b1) begin
            errors++; $display("FAIL bp_run: cpu_run=%b expected 1", cpu_run);
        end
        if (ld_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready: ld_ready=%b expected 0", ld_ready);
        end
        send_byte(8'h77, 1'b1);
        vectors++;
        if (ld_ready !== 1'b0 || cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL bp_byte65: ready=%b run=%b expected 0/1", ld_ready, cpu_run);
        end
        check_instr(5'd0, bp_word(0), "bp_pc0");
        check_instr(5'd17, bp_word(17), "bp_pc17");
        check_instr(5'd30, bp_word(30), "bp_pc30");
        check_instr(5'd31, bp_word(31), "bp_pc31");
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        vectors += 2;
        if (ld_ready !== 1'b1) begin
            errors++; $display("FAIL rload_ready: ld_ready=%b expected 1", ld_ready);
        end
        if (dut.u_loader.waddr_q !== 5'd0) begin
            errors++; $display("FAIL rload_waddr: waddr=%0d expected 0", dut.u_loader.waddr_q);
        end
        @(negedge clock);
        reset_n = 1'b1;
        send_byte(8'h44, 1'b0);
        send_byte(8'h07, 1'b1);
        check_instr(5'd0, 12'h744, "rload_pc0");
        check_instr(5'd1, 12'h000, "rload_pc1");
    endtask

    initial begin
        reset_n = 1'b1;
        ld_valid = 1'b0;
        ld_data = 8'h00;
        ld_last = 1'b0;
        pc = '0;
        addr = '0;
        wdata = '0;
        wr = 1'b0;
        test_reset();
        test_normal_load();
        test_dmem();
        test_reset_mid_run();
        test_dmem_prerun();
        test_errors();
        test_back_pressure();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
